fruit_renderer: RTL and testbench

- Downstream of the moving-fruit stage: watches the fruit coordinates and redraws the fruit on the 160x120 VGA framebuffer whenever they change.
- On each change it erases the previously drawn FRUIT_SIZE x FRUIT_SIZE block with background colour, then plots the block at the new position.
- Shares the VGA plot port with the snake drawer through a req/grant arbiter; it plots only while granted.

---
 rtl/fruit_renderer.sv | 179 +++++++++++++++++
 tb/tb_fruit_renderer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_renderer.sv
// Redraws the fruit block on the 160x120 framebuffer whenever its coordinates change:
// erase the old block in the background colour, then plot the new one, only while granted.
module fruit_renderer #(
    parameter int         FRUIT_SIZE   = 2,
    parameter logic [2:0] FRUIT_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] fruit_x,
    input  logic [6:0] fruit_y,
    input  logic       vga_grant,
    output logic       vga_req,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       draw_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GRANT,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST  = 2'(FRUIT_SIZE - 1);
    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_new_x;
    logic [6:0] r_new_y;
    logic [7:0] r_drawn_x;
    logic [6:0] r_drawn_y;
    logic       r_drawn_valid;
    logic [1:0] r_dx;
    logic [1:0] r_dy;

    logic       w_changed;
    logic       w_last_pix;
    logic       w_scanning;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_clip;

    logic       w_req;
    logic       w_plot;
    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_colour;
    logic       w_done;
    logic       w_busy;

    assign w_changed  = !r_drawn_valid || ({fruit_x, fruit_y} != {r_drawn_x, r_drawn_y});
    assign w_last_pix = (r_dx == LAST) && (r_dy == LAST);
    assign w_scanning = (r_state == S_ERASE) || (r_state == S_DRAW);

    // Erase walks the block already on screen; draw walks the snapshotted target.
    assign w_base_x = (r_state == S_ERASE) ? r_drawn_x : r_new_x;
    assign w_base_y = (r_state == S_ERASE) ? r_drawn_y : r_new_y;
    assign w_sum_x  = {1'b0, w_base_x} + {7'b0, r_dx};
    assign w_sum_y  = {1'b0, w_base_y} + {6'b0, r_dy};
    assign w_clip   = (w_sum_x > X_LIM) || (w_sum_y > Y_LIM);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (w_changed) w_next_state = S_WAIT_GRANT;
            S_WAIT_GRANT: if (vga_grant) w_next_state = r_drawn_valid ? S_ERASE : S_DRAW;
            S_ERASE:      if (vga_grant && w_last_pix) w_next_state = S_DRAW;
            S_DRAW:       if (vga_grant && w_last_pix) w_next_state = S_DONE;
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_req    = 1'b0;
        w_plot   = 1'b0;
        w_x      = vga_x;
        w_y      = vga_y;
        w_colour = vga_colour;
        w_done   = 1'b0;
        w_busy   = (w_next_state != S_IDLE);
        case (r_state)
            S_IDLE:       w_req = w_changed;
            S_WAIT_GRANT: w_req = 1'b1;
            S_ERASE, S_DRAW: begin
                w_req = 1'b1;
                if (vga_grant) begin
                    w_plot   = !w_clip;
                    w_x      = w_sum_x[7:0];
                    w_y      = w_sum_y[6:0];
                    w_colour = (r_state == S_ERASE) ? BG_COLOUR : FRUIT_COLOUR;
                end
            end
            S_DONE:       w_done = 1'b1;
            default:      w_req = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_req    <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            draw_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vga_req    <= w_req;
            vga_x      <= w_x;
            vga_y      <= w_y;
            vga_colour <= w_colour;
            vga_plot   <= w_plot;
            draw_done  <= w_done;
            busy       <= w_busy;
        end
    end

    // Snapshot, pixel counters and the record of what is currently on screen.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_new_x       <= '0;
            r_new_y       <= '0;
            r_drawn_x     <= '0;
            r_drawn_y     <= '0;
            r_drawn_valid <= 1'b0;
            r_dx          <= '0;
            r_dy          <= '0;
        end else begin
            if (r_state == S_IDLE && w_changed) begin
                r_new_x <= fruit_x;
                r_new_y <= fruit_y;
            end
            if (r_state == S_WAIT_GRANT) begin
                r_dx <= '0;
                r_dy <= '0;
            end else if (w_scanning && vga_grant) begin
                if (w_last_pix) begin
                    r_dx <= '0;
                    r_dy <= '0;
                end else if (r_dx == LAST) begin
                    r_dx <= '0;
                    r_dy <= r_dy + 2'd1;
                end else begin
                    r_dx <= r_dx + 2'd1;
                end
            end
            if (r_state == S_DONE) begin
                r_drawn_x     <= r_new_x;
                r_drawn_y     <= r_new_y;
                r_drawn_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fruit_renderer.sv
// Directed and randomized redraws of fruit_renderer, checked against a block-level model:
// expected pixel lists per redraw, done timing from granted-cycle counting, bus idle rules.
module tb_fruit_renderer;

    localparam int         FS = 2;
    localparam logic [2:0] FR = 3'b100;
    localparam logic [2:0] BG = 3'b000;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] fruit_x = '0;
    logic [6:0] fruit_y = '0;
    logic       vga_grant = 1'b0;
    logic       vga_req;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       draw_done;
    logic       busy;

    fruit_renderer dut (
        .clock     (clock),
        .resetn    (resetn),
        .fruit_x   (fruit_x),
        .fruit_y   (fruit_y),
        .vga_grant (vga_grant),
        .vga_req   (vga_req),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .draw_done (draw_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    bit   m_valid = 1'b0;
    int   m_x = 0;
    int   m_y = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Visible pixels of one block in raster order; off-screen slots produce nothing.
    task automatic push_block(input int bx, input int by, input logic [2:0] c);
        pix_t p;
        for (int dy = 0; dy < FS; dy++) begin
            for (int dx = 0; dx < FS; dx++) begin
                if (bx + dx <= 159 && by + dy <= 119) begin
                    p.x = 8'(bx + dx);
                    p.y = 7'(by + dy);
                    p.c = c;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // mode 0: grant always high, 1: random grant, 2: 5 low cycles after request, 3 more after pixel 2.
    task automatic redraw(input int nx, input int ny, input int mode,
                          input int mv_after, input int mvx, input int mvy);
        int   slots;
        int   granted;
        int   done_at;
        int   plots;
        int   low_cnt;
        int   drop;
        bit   started;
        bit   req_seen;
        bit   was_req;
        bit   finished;
        logic g;
        pix_t p;
        exp_q.delete();
        slots = 0;
        if (m_valid) begin
            push_block(m_x, m_y, BG);
            slots += FS * FS;
        end
        push_block(nx, ny, FR);
        slots += FS * FS;
        granted = 0; done_at = -1; plots = 0; low_cnt = 0; drop = 0;
        started = 0; req_seen = 0; finished = 0;
        fruit_x = 8'(nx);
        fruit_y = 7'(ny);
        for (int t = 0; t < 300 && !finished; t++) begin
            g = vga_grant;
            was_req = req_seen;
            tick();
            // One granted cycle starts the redraw; each further granted cycle consumes one slot.
            if (was_req && g) begin
                if (!started) started = 1;
                else if (granted < slots) begin
                    granted++;
                    if (granted == slots) done_at = cyc + 1;
                end
            end
            if (t == 0) check("req_rise", vga_req, 1);
            if (vga_req) begin
                req_seen = 1;
                check("busy_while_req", busy, 1);
            end
            if (vga_plot) begin
                plots++;
                check("plot_needs_grant", g, 1);
                if (exp_q.size() == 0) check("extra_plot", 1, 0);
                else begin
                    p = exp_q.pop_front();
                    check("pixel", {vga_x, vga_y, vga_colour}, p);
                end
            end
            if (draw_done) begin
                check("done_cycle", cyc, done_at);
                check("done_req_low", vga_req, 0);
                check("done_busy_low", busy, 0);
                check("pixels_left", exp_q.size(), 0);
                finished = 1;
            end
            if (mv_after > 0 && plots == mv_after) begin
                fruit_x = 8'(mvx);
                fruit_y = 7'(mvy);
            end
            case (mode)
                0: vga_grant = 1'b1;
                1: vga_grant = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!req_seen) vga_grant = 1'b0;
                    else if (low_cnt < 5) begin
                        low_cnt++;
                        vga_grant = 1'b0;
                    end else if (plots == 2 && drop < 3) begin
                        drop++;
                        vga_grant = 1'b0;
                    end else vga_grant = 1'b1;
                end
            endcase
        end
        if (!finished) check("redraw_timeout", 0, 1);
        m_valid = 1;
        m_x = nx;
        m_y = ny;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_quiet", {vga_req, vga_plot, draw_done, busy}, 4'b0000);
        end
    endtask

    initial begin
        int nx;
        int ny;
        int seen;
        resetn = 1'b0;
        tick();
        tick();
        check("reset_outputs", {vga_req, vga_x, vga_y, vga_colour, vga_plot, draw_done, busy}, 0);
        resetn = 1'b1;

        redraw(10, 20, 0, 0, 0, 0);
        idle_check(4);
        redraw(12, 20, 0, 0, 0, 0);
        idle_check(2);
        redraw(159, 119, 0, 0, 0, 0);
        idle_check(2);
        redraw(60, 60, 2, 0, 0, 0);
        redraw(12, 20, 0, 5, 30, 40);
        redraw(30, 40, 0, 0, 0, 0);
        idle_check(2);

        for (int i = 0; i < 12; i++) begin
            nx = (i % 4 == 0) ? $urandom_range(157, 159) : $urandom_range(0, 159);
            ny = (i % 4 == 1) ? $urandom_range(117, 119) : $urandom_range(0, 119);
            if (nx == m_x && ny == m_y) nx = (nx + 1) % 160;
            redraw(nx, ny, 1, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) idle_check(1);
        end

        // Abort a redraw during its erase phase; nothing is remembered afterwards.
        fruit_x = 8'd40;
        fruit_y = 7'd50;
        vga_grant = 1'b1;
        seen = 0;
        for (int t = 0; t < 20 && seen < 2; t++) begin
            tick();
            if (vga_plot) seen++;
        end
        check("erase_started", seen, 2);
        check("erase_colour", vga_colour, BG);
        resetn = 1'b0;
        tick();
        check("reset_mid_outputs", {vga_req, vga_x, vga_y, vga_colour, vga_plot, draw_done, busy}, 0);
        m_valid = 0;
        fruit_x = 8'd5;
        fruit_y = 7'd5;
        resetn = 1'b1;
        redraw(5, 5, 0, 0, 0, 0);
        idle_check(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
